// File: rtl/rv32_hazard_ctrl.sv
// RV32 pipeline hazard controller: PC enable/busy, IF/ID flush,
// EX bubble insertion, halt/resume sequencing and stall statistics.
module rv32_hazard_ctrl #(
  parameter int unsigned INIT_CYCLES  = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        halt_req,
  input  logic        resume,
  input  logic        redirect,
  input  logic        mem_wait,
  input  logic        load_use,
  input  logic        clr_stats,
  output logic        pc_enable,
  output logic        pc_busy,
  output logic        flush,
  output logic        bubble_ex,
  output logic        halted,
  output logic [2:0]  state,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_RUN   = 3'd1,
    S_STALL = 3'd2,
    S_FLUSH = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [3:0] C_INIT  = 4'(INIT_CYCLES - 1);
  localparam logic [3:0] C_FLUSH = 4'(FLUSH_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [15:0] r_stall_cnt;

  logic w_run;
  logic w_stall;
  logic w_flush_st;
  logic w_init;
  logic w_halt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_INIT;
      r_cnt   <= C_INIT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_INIT: begin
        if (r_cnt == 4'd0) w_state_nxt = S_RUN;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      S_RUN: begin
        if (halt_req) begin
          w_state_nxt = S_HALT;
        end else if (redirect) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = C_FLUSH;
        end else if (mem_wait) begin
          w_state_nxt = S_STALL;
        end
      end
      S_STALL: begin
        if (halt_req)       w_state_nxt = S_HALT;
        else if (!mem_wait) w_state_nxt = S_RUN;
      end
      S_FLUSH: begin
        if (halt_req) begin
          w_state_nxt = S_HALT;
        end else if (redirect) begin
          w_cnt_nxt = C_FLUSH;
        end else if (mem_wait) begin
          w_cnt_nxt = r_cnt;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_HALT: begin
        if (resume && !halt_req) begin
          w_state_nxt = S_FLUSH;
          w_cnt_nxt   = C_FLUSH;
        end
      end
      default: begin
        w_state_nxt = S_INIT;
        w_cnt_nxt   = C_INIT;
      end
    endcase
  end

  assign w_init     = (r_state == S_INIT);
  assign w_run      = (r_state == S_RUN);
  assign w_stall    = (r_state == S_STALL);
  assign w_flush_st = (r_state == S_FLUSH);
  assign w_halt     = (r_state == S_HALT);

  // redirect and halt_req outrank a hazard raised in the same RUN cycle
  assign pc_busy = (w_run & (mem_wait | load_use) & ~redirect & ~halt_req)
                 | w_stall
                 | (w_flush_st & mem_wait);

  assign bubble_ex = w_run & load_use & ~mem_wait & ~redirect & ~halt_req;
  assign pc_enable = w_run | w_stall | w_flush_st;
  assign flush     = w_init | w_flush_st | w_halt;
  assign halted    = w_halt;
  assign state     = r_state;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= 16'd0;
    end else if (clr_stats) begin
      r_stall_cnt <= 16'd0;
    end else if (pc_busy && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_rv32_hazard_ctrl.sv
// Directed bench for rv32_hazard_ctrl: reset/INIT, redirect, load-use,
// flush under mem_wait, stall/halt/resume, mid-op reset, stats saturation.
module tb_rv32_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic        halt_req;
  logic        resume;
  logic        redirect;
  logic        mem_wait;
  logic        load_use;
  logic        clr_stats;
  logic        pc_enable;
  logic        pc_busy;
  logic        flush;
  logic        bubble_ex;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] stall_cnt;

  int n_tests;
  int n_fail;
  int exp_cnt;

  logic [7:0] obs;
  assign obs = {state, pc_enable, pc_busy, flush, bubble_ex, halted};

  rv32_hazard_ctrl #(.INIT_CYCLES(2), .FLUSH_CYCLES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .halt_req  (halt_req),
    .resume    (resume),
    .redirect  (redirect),
    .mem_wait  (mem_wait),
    .load_use  (load_use),
    .clr_stats (clr_stats),
    .pc_enable (pc_enable),
    .pc_busy   (pc_busy),
    .flush     (flush),
    .bubble_ex (bubble_ex),
    .halted    (halted),
    .state     (state),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {state, pc_enable, pc_busy, flush, bubble_ex, halted}
  function automatic logic [7:0] ev(input logic [2:0] st, input logic en,
                                    input logic bz, input logic fl,
                                    input logic bb, input logic hl);
    return {st, en, bz, fl, bb, hl};
  endfunction

  localparam logic [2:0] INIT = 3'd0, RUN = 3'd1, STALL = 3'd2;
  localparam logic [2:0] FLSH = 3'd3, HALT = 3'd4;

  // inputs change 1 time unit after the rising edge; checks at +2
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    halt_req = 0; resume = 0; redirect = 0;
    mem_wait = 0; load_use = 0; clr_stats = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #3;
    n_tests++;
    if (obs !== ev(INIT, 0, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_outs got %b exp %b", obs, ev(INIT, 0, 0, 1, 0, 0));
    end
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt got %h exp 0000", stall_cnt);
    end
    tick();
    // noise on inputs must be ignored during INIT
    rst_n = 1; mem_wait = 1; redirect = 1; halt_req = 1;
    settle();
    n_tests++;
    if (obs !== ev(INIT, 0, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL init_c1 got %b exp %b", obs, ev(INIT, 0, 0, 1, 0, 0));
    end
    tick();
    settle();
    n_tests++;
    if (obs !== ev(INIT, 0, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL init_c2 got %b exp %b", obs, ev(INIT, 0, 0, 1, 0, 0));
    end
    idle_inputs();
    tick();
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL init_run got %b exp %b", obs, ev(RUN, 1, 0, 0, 0, 0));
    end
    exp_cnt = 0;
  endtask

  task automatic test_redirect();
    redirect = 1; load_use = 1;
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL redir_wins got %b exp %b", obs, ev(RUN, 1, 0, 0, 0, 0));
    end
    tick();
    idle_inputs();
    settle();
    n_tests++;
    if (obs !== ev(FLSH, 1, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL redir_f1 got %b exp %b", obs, ev(FLSH, 1, 0, 1, 0, 0));
    end
    tick();
    settle();
    n_tests++;
    if (obs !== ev(FLSH, 1, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL redir_f2 got %b exp %b", obs, ev(FLSH, 1, 0, 1, 0, 0));
    end
    tick();
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL redir_run got %b exp %b", obs, ev(RUN, 1, 0, 0, 0, 0));
    end
    n_tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL redir_cnt got %0d exp %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_load_use();
    load_use = 1;
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 1, 0, 1, 0)) begin
      n_fail++;
      $display("FAIL lu_bubble got %b exp %b", obs, ev(RUN, 1, 1, 0, 1, 0));
    end
    tick();
    exp_cnt++;
    load_use = 0;
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL lu_after got %b exp %b", obs, ev(RUN, 1, 0, 0, 0, 0));
    end
    n_tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL lu_cnt got %0d exp %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_flush_wait();
    redirect = 1;
    tick();
    redirect = 0; mem_wait = 1;
    for (int i = 0; i < 3; i++) begin
      settle();
      n_tests++;
      if (obs !== ev(FLSH, 1, 1, 1, 0, 0)) begin
        n_fail++;
        $display("FAIL fw_hold%0d got %b exp %b", i, obs, ev(FLSH, 1, 1, 1, 0, 0));
      end
      tick();
      exp_cnt++;
    end
    mem_wait = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if (obs !== ev(FLSH, 1, 0, 1, 0, 0)) begin
        n_fail++;
        $display("FAIL fw_drain%0d got %b exp %b", i, obs, ev(FLSH, 1, 0, 1, 0, 0));
      end
      tick();
    end
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL fw_run got %b exp %b", obs, ev(RUN, 1, 0, 0, 0, 0));
    end
    n_tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL fw_cnt got %0d exp %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_halt();
    mem_wait = 1;
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL h_runwait got %b exp %b", obs, ev(RUN, 1, 1, 0, 0, 0));
    end
    tick();
    exp_cnt++;
    redirect = 1;
    tick();
    exp_cnt++;
    redirect = 0;
    settle();
    n_tests++;
    if (obs !== ev(STALL, 1, 1, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL h_stall_redir got %b exp %b", obs, ev(STALL, 1, 1, 0, 0, 0));
    end
    halt_req = 1;
    tick();
    exp_cnt++;
    settle();
    n_tests++;
    if (obs !== ev(HALT, 0, 0, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL h_halt got %b exp %b", obs, ev(HALT, 0, 0, 1, 0, 1));
    end
    resume = 1;
    tick();
    resume = 0;
    settle();
    n_tests++;
    if (obs !== ev(HALT, 0, 0, 1, 0, 1)) begin
      n_fail++;
      $display("FAIL h_resume_blk got %b exp %b", obs, ev(HALT, 0, 0, 1, 0, 1));
    end
    halt_req = 0; mem_wait = 0; resume = 1;
    tick();
    resume = 0;
    for (int i = 0; i < 2; i++) begin
      settle();
      n_tests++;
      if (obs !== ev(FLSH, 1, 0, 1, 0, 0)) begin
        n_fail++;
        $display("FAIL h_flush%0d got %b exp %b", i, obs, ev(FLSH, 1, 0, 1, 0, 0));
      end
      tick();
    end
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL h_run got %b exp %b", obs, ev(RUN, 1, 0, 0, 0, 0));
    end
    n_tests++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      n_fail++;
      $display("FAIL h_cnt got %0d exp %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_mid_reset();
    mem_wait = 1;
    tick();
    tick();
    #2;
    rst_n = 0;
    #1;
    n_tests++;
    if ({obs, stall_cnt} !== {ev(INIT, 0, 0, 1, 0, 0), 16'd0}) begin
      n_fail++;
      $display("FAIL mr_async got %b/%0d exp %b/0", obs, stall_cnt,
               ev(INIT, 0, 0, 1, 0, 0));
    end
    idle_inputs();
    tick();
    rst_n = 1;
    tick();
    settle();
    n_tests++;
    if (obs !== ev(INIT, 0, 0, 1, 0, 0)) begin
      n_fail++;
      $display("FAIL mr_init got %b exp %b", obs, ev(INIT, 0, 0, 1, 0, 0));
    end
    tick();
    settle();
    n_tests++;
    if (obs !== ev(RUN, 1, 0, 0, 0, 0)) begin
      n_fail++;
      $display("FAIL mr_run got %b exp %b", obs, ev(RUN, 1, 0, 0, 0, 0));
    end
    exp_cnt = 0;
  endtask

  task automatic test_saturate();
    mem_wait = 1;
    for (int i = 0; i < 65540; i++) tick();
    settle();
    n_tests++;
    if ({state, stall_cnt} !== {STALL, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL sat_hold got %0d/%h exp 2/ffff", state, stall_cnt);
    end
    tick();
    settle();
    n_tests++;
    if (stall_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL sat_stay got %h exp ffff", stall_cnt);
    end
    clr_stats = 1;
    tick();
    clr_stats = 0;
    settle();
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL sat_clr got %h exp 0000", stall_cnt);
    end
    tick();
    settle();
    n_tests++;
    if (stall_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL sat_restart got %h exp 0001", stall_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    exp_cnt = 0;
    test_reset();
    test_redirect();
    test_load_use();
    test_flush_wait();
    test_halt();
    test_mid_reset();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
